gpio_bus_arbiter: RTL

//  Two-requester arbiter and strobe sequencer for the 6-bit-address / 8-bit-data asynchronous register bus
//  of the GPIO peripheral chip (CEb/OEb/WEb, active-low). It grants one requester at a time and generates

---
 rtl/gpio_bus_pkg.sv | 33 +++
 rtl/gpio_bus_rr_arb.sv | 35 +++
 rtl/gpio_bus_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the GPIO peripheral register-bus arbiter.
// Holds the FSM state type, the latched-transfer record and the chip's register map.
package gpio_bus_pkg;

  localparam int PH_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  localparam logic [5:0] ADDR_DDRA      = 6'd0;
  localparam logic [5:0] ADDR_PORTA     = 6'd2;
  localparam logic [5:0] ADDR_SPI_DATA  = 6'd7;
  localparam logic [5:0] ADDR_UART_DATA = 6'd10;
  localparam logic [5:0] ADDR_IRQ       = 6'd13;
  localparam logic [5:0] ADDR_MEM0      = 6'd48;

  // Phase counter preload: a phase of n cycles starts at n-1 and exits at 0.
  function automatic logic [PH_W-1:0] ph_load(input int n);
    return (n > 0) ? PH_W'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/gpio_bus_rr_arb.sv
// Two-way requester pick for the GPIO bus arbiter; round-robin by default.
// Define GPIO_ARB_FIXED_PRIO_EN to make port 0 win every contention.
module gpio_bus_rr_arb (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       valid,
  output logic       winner
);

  assign valid = |req;

`ifdef GPIO_ARB_FIXED_PRIO_EN
  assign winner = ~req[0];

  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_n, update};
`else
  logic last_q;

  // Reset to port 1 so that port 0 wins the first contention.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= winner;
    end
  end

  assign winner = (&req) ? ~last_q : req[1];
`endif

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-port arbiter and CEb/OEb/WEb strobe sequencer for the GPIO chip's 6-bit/8-bit register bus.
// Build option: GPIO_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of round-robin.
module gpio_bus_arbiter
  import gpio_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [11:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [1:0]  ack_o,
  output logic [15:0] rdata_o,
  output logic        grant_o,
  output logic        busy_o,
  output logic [5:0]  bus_addr_o,
  output logic [7:0]  bus_d_o,
  input  logic [7:0]  bus_d_i,
  output logic        bus_d_oe_o,
  output logic        bus_ceb_o,
  output logic        bus_oeb_o,
  output logic        bus_web_o
);

  localparam logic [PH_W-1:0] SETUP_LD  = ph_load(SETUP_CYC);
  localparam logic [PH_W-1:0] STROBE_LD = ph_load(STROBE_CYC);
  localparam logic [PH_W-1:0] HOLD_LD   = ph_load(HOLD_CYC);

  state_e          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  xfer_t           xfer_q, req_xfer;
  logic            grant_q;
  logic [15:0]     rdata_q;
  logic            arb_valid, arb_winner, arb_update;
  logic            in_xfer, strobe, read_sample;

  assign arb_update = (state_q == IDLE) && arb_valid;

  gpio_bus_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .req    (req_i),
    .update (arb_update),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_comb begin
    req_xfer = arb_winner ? '{we: we_i[1], addr: addr_i[11:6], wdata: wdata_i[15:8]}
                          : '{we: we_i[0], addr: addr_i[5:0],  wdata: wdata_i[7:0]};
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          if (SETUP_CYC > 0) begin
            state_d = SETUP;
            ph_d    = SETUP_LD;
          end else begin
            state_d = STROBE;
            ph_d    = STROBE_LD;
          end
        end
      end
      SETUP: begin
        if (ph_q == '0) begin
          state_d = STROBE;
          ph_d    = STROBE_LD;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      STROBE: begin
        if (ph_q == '0) begin
          if (HOLD_CYC > 0) begin
            state_d = HOLD;
            ph_d    = HOLD_LD;
          end else begin
            state_d = DONE;
          end
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      HOLD: begin
        if (ph_q == '0) state_d = DONE;
        else            ph_d    = ph_q - PH_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign read_sample = (state_q == STROBE) && (ph_q == '0) && !xfer_q.we;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      xfer_q  <= '0;
      grant_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      // Requester inputs are only looked at on the grant edge; afterwards the latched copy drives the bus.
      if (arb_update) begin
        grant_q <= arb_winner;
        xfer_q  <= req_xfer;
      end
      if (read_sample) begin
        if (grant_q) rdata_q[15:8] <= bus_d_i;
        else         rdata_q[7:0]  <= bus_d_i;
      end
    end
  end

  assign in_xfer = state_q inside {SETUP, STROBE, HOLD};
  assign strobe  = (state_q == STROBE);

  // Strobes decode straight from the state register so reset releases them asynchronously.
  assign bus_ceb_o  = ~in_xfer;
  assign bus_oeb_o  = ~(strobe & ~xfer_q.we);
  assign bus_web_o  = ~(strobe & xfer_q.we);
  assign bus_d_oe_o = in_xfer & xfer_q.we;
  assign bus_addr_o = xfer_q.addr;
  assign bus_d_o    = xfer_q.wdata;

  assign ack_o   = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign rdata_o = rdata_q;

endmodule
